apb_timer_resp: RTL and testbench
=================================

// Module: apb_timer_resp
// PURPOSE
//  APB3 responder in the fabric, driven by the MSS APB master port (MSSPSEL/MSSPENABLE/...).
//  Holds a memory-mapped 32-bit down-counter timer; interrupt goes back to the MSS FABINT input.
//  Runs entirely on FAB_CLK; one fixed wait state per transfer.
// PARAMETERS
//  ADDR_W      8    PADDR width; decode uses PADDR[4:2], upper bits must be 0 or PSLVERR
//  PRESCALE_W  16   prescaler register width (used only with APB_TIMER_PRESCALE_EN)
// PORTS
//  FAB_CLK    in   1       single clock (MSS CCC FAB_CLK)
//  FAB_RESET  in   1       asynchronous reset, active-high
//  PSEL       in   1       APB select
//  PENABLE    in   1       APB access phase
//  PWRITE     in   1       1 = write
//  PADDR      in   ADDR_W  byte address, word aligned
//  PWDATA     in   32      write data
//  PRDATA     out  32      read data, valid while PREADY=1
//  PREADY     out  1       transfer complete
//  PSLVERR    out  1       error, valid while PREADY=1
//  TIMER_INT  out  1       level interrupt = PEND & IE
// BEHAVIOUR
//  Reset: all regs 0, PRDATA=0, PREADY=0, PSLVERR=0, TIMER_INT=0, FSM=IDLE.
//  Reset mid-transfer: FSM -> IDLE, no register update committed.
//  Map: 0x00 CTRL [0]EN [1]PERIODIC [2]IE (RW); 0x04 LOAD (RW, write also copies to VALUE);
//    0x08 VALUE (RO); 0x0C STATUS [0]PEND (W1C); 0x10 SCRATCH (RW).
//  FSM IDLE -> WAIT on PSEL&!PENABLE (setup); WAIT -> DONE next cycle (PREADY=0 in WAIT);
//    DONE: PREADY=1 one cycle, then -> IDLE. PSEL low in WAIT -> IDLE, no commit.
//  Write commits in DONE cycle only. PRDATA/PSLVERR registered on WAIT->DONE; PRDATA=0 on writes.
//  PSLVERR=1: unmapped address, nonzero upper PADDR bits, or write to VALUE (write dropped);
//    error reads return 0.
//  Counter, per tick while EN=1: VALUE==0 -> PEND<=1, then PERIODIC ? VALUE<=LOAD : EN<=0;
//    else VALUE<=VALUE-1. Period = LOAD+1 ticks. EN=0 freezes VALUE.
//  Simultaneous: LOAD write beats tick (VALUE<=new LOAD); PEND set beats W1C clear;
//    CTRL write of EN beats one-shot auto-clear in same cycle.
//  TIMER_INT combinational from PEND and IE flops only (glitch-free).
// CONFIGURATION
//  APB_TIMER_PRESCALE_EN defined: reg 0x14 PRESCALE (RW, PRESCALE_W bits); tick every
//    PRESCALE+1 FAB_CLK cycles; prescale counter clears on CTRL/LOAD write and when EN=0.
//  Undefined: tick every FAB_CLK cycle; 0x14 is unmapped (PSLVERR=1, PRDATA=0).
// STRUCTURE
//  Package apb_timer_pkg: register offsets, CTRL/STATUS bit indices, FSM state enum
//    (IDLE/WAIT/DONE), 32-bit data width constant.
//  Sub-module apb_timer_core: tick generation, VALUE/PEND/EN-clear logic; APB FSM and
//    register decode stay in apb_timer_resp.
// TESTING
//  Read each reg after reset -> PRDATA=0, PSLVERR=0, PREADY high exactly 2 cycles after setup.
//  Write LOAD=3, CTRL=0x5 (EN,IE, one-shot) -> PEND and TIMER_INT rise 4 ticks later, EN reads 0,
//    VALUE stays 0.
//  LOAD=2, CTRL=0x7 periodic -> PEND every 3 ticks; W1C STATUS=1 clears it; clear on expiry cycle -> PEND=1.
//  Read 0x1C and write 0x08 -> PSLVERR=1 with PREADY, PRDATA=0, VALUE unchanged.
//  Assert FAB_RESET during WAIT of write SCRATCH=0xDEADBEEF -> SCRATCH reads 0, PREADY=0.
//  With APB_TIMER_PRESCALE_EN, PRESCALE=4, LOAD=1 -> PEND after 10 FAB_CLK; without, 0x14 errors.

Source files
------------

// File: rtl/apb_timer_pkg.sv
// rtl/apb_timer_pkg.sv - shared constants and types for the APB timer responder
//
// Holds register word indices (PADDR[4:2]), CTRL/STATUS bit positions,
// the APB transfer state enum and the data width.
package apb_timer_pkg;

  localparam int DATA_W = 32;

  // Register word indices; byte offset = index * 4.
  localparam logic [2:0] REG_CTRL     = 3'd0;  // 0x00
  localparam logic [2:0] REG_LOAD     = 3'd1;  // 0x04
  localparam logic [2:0] REG_VALUE    = 3'd2;  // 0x08
  localparam logic [2:0] REG_STATUS   = 3'd3;  // 0x0C
  localparam logic [2:0] REG_SCRATCH  = 3'd4;  // 0x10
  localparam logic [2:0] REG_PRESCALE = 3'd5;  // 0x14

  localparam int CTRL_EN       = 0;
  localparam int CTRL_PERIODIC = 1;
  localparam int CTRL_IE       = 2;
  localparam int STATUS_PEND   = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } apb_state_t;

endpackage

// File: rtl/apb_timer_core.sv
// rtl/apb_timer_core.sv - tick generation and down-counter state of the APB timer
//
// Optional feature macro: APB_TIMER_PRESCALE_EN (adds the i_prescale port).
// Ports:
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_prescale        tick divider (tick every i_prescale+1 cycles), macro builds only
//   i_ctrl_wr         CTRL write commits this cycle, i_ctrl_en is the written EN bit
//   i_periodic        current CTRL.PERIODIC
//   i_load_wr         LOAD write commits this cycle, i_load_data is the written value
//   i_load            current LOAD register, used for periodic reload
//   i_pend_clr        W1C of STATUS.PEND commits this cycle
//   o_en, o_value, o_pend   timer state flops
module apb_timer_core
  import apb_timer_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
`ifdef APB_TIMER_PRESCALE_EN
  input  logic [DATA_W-1:0] i_prescale,
`endif
  input  logic              i_ctrl_wr,
  input  logic              i_ctrl_en,
  input  logic              i_periodic,
  input  logic              i_load_wr,
  input  logic [DATA_W-1:0] i_load_data,
  input  logic [DATA_W-1:0] i_load,
  input  logic              i_pend_clr,
  output logic              o_en,
  output logic [DATA_W-1:0] o_value,
  output logic              o_pend
);

  logic              r_en;
  logic [DATA_W-1:0] r_value;
  logic              r_pend;
  logic              w_tick;
  logic              w_expire;

`ifdef APB_TIMER_PRESCALE_EN
  logic [DATA_W-1:0] r_pre_cnt;

  // >= rather than == so a PRESCALE lowered below the running count
  // still produces a tick instead of wrapping the full counter range.
  assign w_tick = r_en && (r_pre_cnt >= i_prescale);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pre_cnt <= '0;
    end else if (i_ctrl_wr || i_load_wr || !r_en || w_tick) begin
      r_pre_cnt <= '0;
    end else begin
      r_pre_cnt <= r_pre_cnt + DATA_W'(1);
    end
  end
`else
  assign w_tick = r_en;
`endif

  assign w_expire = w_tick && (r_value == '0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_en    <= 1'b0;
      r_value <= '0;
      r_pend  <= 1'b0;
    end else begin
      // Expiry set wins over a same-cycle W1C clear.
      if (w_expire) begin
        r_pend <= 1'b1;
      end else if (i_pend_clr) begin
        r_pend <= 1'b0;
      end

      // A LOAD write overrides whatever the tick would have done to VALUE.
      if (i_load_wr) begin
        r_value <= i_load_data;
      end else if (w_tick) begin
        if (r_value == '0) begin
          r_value <= i_periodic ? i_load : r_value;
        end else begin
          r_value <= r_value - DATA_W'(1);
        end
      end

      // A CTRL write of EN overrides the one-shot auto-clear.
      if (i_ctrl_wr) begin
        r_en <= i_ctrl_en;
      end else if (w_expire && !i_periodic) begin
        r_en <= 1'b0;
      end
    end
  end

  assign o_en    = r_en;
  assign o_value = r_value;
  assign o_pend  = r_pend;

endmodule

// File: rtl/apb_timer_resp.sv
// rtl/apb_timer_resp.sv - APB3 responder with a 32-bit down-counter timer
//
// Optional feature macro: APB_TIMER_PRESCALE_EN (PRESCALE register at 0x14).
// Ports:
//   FAB_CLK, FAB_RESET   clock, asynchronous active-high reset
//   PSEL, PENABLE, PWRITE, PADDR, PWDATA   APB request
//   PRDATA, PREADY, PSLVERR                APB response (registered)
//   TIMER_INT                              level interrupt, PEND & IE
// One wait state per transfer: setup -> WAIT (PREADY=0) -> DONE (PREADY=1).
module apb_timer_resp
  import apb_timer_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int PRESCALE_W = 16
) (
  input  logic              FAB_CLK,
  input  logic              FAB_RESET,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic              TIMER_INT
);

  apb_state_t        r_state;
  logic [2:0]        r_idx;
  logic              r_upper_err;
  logic              r_write;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_prdata;
  logic              r_pready;
  logic              r_pslverr;

  logic              r_periodic;
  logic              r_ie;
  logic [DATA_W-1:0] r_load;
  logic [DATA_W-1:0] r_scratch;

  logic              w_en;
  logic [DATA_W-1:0] w_value;
  logic              w_pend;
  logic              w_err;
  logic [DATA_W-1:0] w_rdata;
  logic              w_commit;
  logic              w_unused_addr;

  // Byte lane bits are ignored; accesses are word aligned.
  assign w_unused_addr = ^PADDR[1:0];

`ifdef APB_TIMER_PRESCALE_EN
  logic [PRESCALE_W-1:0] r_prescale;
  logic [DATA_W-1:0]     w_prescale;
  assign w_prescale = {{(DATA_W-PRESCALE_W){1'b0}}, r_prescale};
`else
  logic [PRESCALE_W-1:0] w_unused_prescale;
  assign w_unused_prescale = '0;
`endif

  // Decode of the latched address; stable from setup until the end of DONE.
  always_comb begin
    w_err   = r_upper_err;
    w_rdata = '0;
    case (r_idx)
      REG_CTRL:    w_rdata = {29'd0, r_ie, r_periodic, w_en};
      REG_LOAD:    w_rdata = r_load;
      REG_VALUE: begin
        w_rdata = w_value;
        if (r_write) begin
          w_err = 1'b1;
        end
      end
      REG_STATUS:  w_rdata = {31'd0, w_pend};
      REG_SCRATCH: w_rdata = r_scratch;
`ifdef APB_TIMER_PRESCALE_EN
      REG_PRESCALE: w_rdata = w_prescale;
`endif
      default:     w_err = 1'b1;
    endcase
  end

  always_ff @(posedge FAB_CLK or posedge FAB_RESET) begin
    if (FAB_RESET) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_upper_err <= 1'b0;
      r_write     <= 1'b0;
      r_wdata     <= '0;
      r_prdata    <= '0;
      r_pready    <= 1'b0;
      r_pslverr   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (PSEL && !PENABLE) begin
            r_state     <= ST_WAIT;
            r_idx       <= PADDR[4:2];
            r_upper_err <= |PADDR[ADDR_W-1:5];
            r_write     <= PWRITE;
            r_wdata     <= PWDATA;
          end
        end
        ST_WAIT: begin
          if (!PSEL) begin
            r_state <= ST_IDLE;
          end else begin
            r_state   <= ST_DONE;
            r_pready  <= 1'b1;
            r_pslverr <= w_err;
            r_prdata  <= (r_write || w_err) ? '0 : w_rdata;
          end
        end
        ST_DONE: begin
          r_state   <= ST_IDLE;
          r_pready  <= 1'b0;
          r_pslverr <= 1'b0;
          r_prdata  <= '0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Writes take effect on the edge that ends the DONE cycle.
  assign w_commit = (r_state == ST_DONE) && r_write && !r_pslverr;

  always_ff @(posedge FAB_CLK or posedge FAB_RESET) begin
    if (FAB_RESET) begin
      r_periodic <= 1'b0;
      r_ie       <= 1'b0;
      r_load     <= '0;
      r_scratch  <= '0;
`ifdef APB_TIMER_PRESCALE_EN
      r_prescale <= '0;
`endif
    end else if (w_commit) begin
      case (r_idx)
        REG_CTRL: begin
          r_periodic <= r_wdata[CTRL_PERIODIC];
          r_ie       <= r_wdata[CTRL_IE];
        end
        REG_LOAD:    r_load    <= r_wdata;
        REG_SCRATCH: r_scratch <= r_wdata;
`ifdef APB_TIMER_PRESCALE_EN
        REG_PRESCALE: r_prescale <= r_wdata[PRESCALE_W-1:0];
`endif
        default: ;
      endcase
    end
  end

  apb_timer_core u_core (
    .i_clk       (FAB_CLK),
    .i_rst       (FAB_RESET),
`ifdef APB_TIMER_PRESCALE_EN
    .i_prescale  (w_prescale),
`endif
    .i_ctrl_wr   (w_commit && (r_idx == REG_CTRL)),
    .i_ctrl_en   (r_wdata[CTRL_EN]),
    .i_periodic  (r_periodic),
    .i_load_wr   (w_commit && (r_idx == REG_LOAD)),
    .i_load_data (r_wdata),
    .i_load      (r_load),
    .i_pend_clr  (w_commit && (r_idx == REG_STATUS) && r_wdata[STATUS_PEND]),
    .o_en        (w_en),
    .o_value     (w_value),
    .o_pend      (w_pend)
  );

  assign PRDATA    = r_prdata;
  assign PREADY    = r_pready;
  assign PSLVERR   = r_pslverr;
  assign TIMER_INT = w_pend & r_ie;

endmodule

// File: tb/tb_apb_timer_resp.sv
// tb/tb_apb_timer_resp.sv - self-checking bench for apb_timer_resp
module tb_apb_timer_resp;

  logic        FAB_CLK = 1'b0;
  logic        FAB_RESET;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic        TIMER_INT;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] d;
    logic        e;
  } exp_t;
  exp_t sb[$];

  apb_timer_resp #(.ADDR_W(8), .PRESCALE_W(16)) dut (
    .FAB_CLK   (FAB_CLK),
    .FAB_RESET (FAB_RESET),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY),
    .PSLVERR   (PSLVERR),
    .TIMER_INT (TIMER_INT)
  );

  always #5 FAB_CLK = ~FAB_CLK;

  // Response monitor: pops the scoreboard whenever PREADY is seen.
  initial begin
    exp_t x;
    forever begin
      @(negedge FAB_CLK);
      if (FAB_RESET) begin
        cyc = 0;
      end else begin
        if (PSEL && !PENABLE) cyc = 0;
        else if (PSEL) cyc++;
        if (PREADY) begin
          n_checks++;
          if (sb.size() == 0) begin
            n_errors++;
            $display("FAIL apb_resp_unexpected: PREADY=1 with no transfer pending, required none");
          end else begin
            x = sb.pop_front();
            if (PRDATA !== x.d || PSLVERR !== x.e || cyc != 2) begin
              n_errors++;
              $display("FAIL apb_resp: prdata=%h pslverr=%b lat=%0d, required prdata=%h pslverr=%b lat=2",
                       PRDATA, PSLVERR, cyc, x.d, x.e);
            end
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic xfer(input bit wr, input logic [7:0] a, input logic [31:0] wd,
                      input logic [31:0] ed, input logic ee);
    exp_t x;
    int   lat;
    x.d = ed;
    x.e = ee;
    @(posedge FAB_CLK); #1;
    sb.push_back(x);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = wd;
    @(posedge FAB_CLK); #1;
    PENABLE = 1'b1;
    lat = 1;
    while (PREADY !== 1'b1 && lat < 10) begin
      @(posedge FAB_CLK); #1;
      lat++;
    end
    @(posedge FAB_CLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic test_reset;
    FAB_RESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
    repeat (3) @(posedge FAB_CLK);
    #1;
    n_checks++;
    if (PREADY !== 1'b0) begin n_errors++; $display("FAIL reset_pready: got %b, required 0", PREADY); end
    n_checks++;
    if (PSLVERR !== 1'b0) begin n_errors++; $display("FAIL reset_pslverr: got %b, required 0", PSLVERR); end
    n_checks++;
    if (PRDATA !== 32'h0) begin n_errors++; $display("FAIL reset_prdata: got %h, required 0", PRDATA); end
    n_checks++;
    if (TIMER_INT !== 1'b0) begin n_errors++; $display("FAIL reset_int: got %b, required 0", TIMER_INT); end
    FAB_RESET = 1'b0;
    for (int i = 0; i < 5; i++) xfer(1'b0, 8'(i * 4), 32'h0, 32'h0, 1'b0);
  endtask

  task automatic test_scratch_load;
    xfer(1'b1, 8'h10, 32'hA5A5_0001, 32'h0, 1'b0);
    xfer(1'b0, 8'h10, 32'h0, 32'hA5A5_0001, 1'b0);
    xfer(1'b1, 8'h04, 32'h0000_0077, 32'h0, 1'b0);
    xfer(1'b0, 8'h04, 32'h0, 32'h0000_0077, 1'b0);
    xfer(1'b0, 8'h08, 32'h0, 32'h0000_0077, 1'b0);
  endtask

  task automatic test_oneshot;
    logic exp_int;
    xfer(1'b1, 8'h04, 32'd3, 32'h0, 1'b0);
    xfer(1'b1, 8'h00, 32'h5, 32'h0, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      @(posedge FAB_CLK); #1;
      exp_int = (k == 4);
      n_checks++;
      if (TIMER_INT !== exp_int) begin
        n_errors++;
        $display("FAIL oneshot_int tick %0d: got %b, required %b", k, TIMER_INT, exp_int);
      end
    end
    xfer(1'b0, 8'h00, 32'h0, 32'h4, 1'b0);
    xfer(1'b0, 8'h08, 32'h0, 32'h0, 1'b0);
    xfer(1'b0, 8'h0C, 32'h0, 32'h1, 1'b0);
    repeat (5) @(posedge FAB_CLK);
    xfer(1'b0, 8'h08, 32'h0, 32'h0, 1'b0);
    xfer(1'b1, 8'h0C, 32'h1, 32'h0, 1'b0);
    xfer(1'b0, 8'h0C, 32'h0, 32'h0, 1'b0);
    n_checks++;
    if (TIMER_INT !== 1'b0) begin n_errors++; $display("FAIL oneshot_w1c_int: got %b, required 0", TIMER_INT); end
  endtask

  task automatic test_periodic;
    logic exp_int;
    xfer(1'b1, 8'h04, 32'd2, 32'h0, 1'b0);
    xfer(1'b1, 8'h00, 32'h7, 32'h0, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      @(posedge FAB_CLK); #1;
      exp_int = (k == 3);
      n_checks++;
      if (TIMER_INT !== exp_int) begin
        n_errors++;
        $display("FAIL periodic_int tick %0d: got %b, required %b", k, TIMER_INT, exp_int);
      end
    end
    // W1C lands on tick 7 (no expiry there), clearing the tick-6 PEND.
    xfer(1'b1, 8'h0C, 32'h1, 32'h0, 1'b0);
    n_checks++;
    if (TIMER_INT !== 1'b0) begin n_errors++; $display("FAIL periodic_w1c: got %b, required 0", TIMER_INT); end
    @(posedge FAB_CLK); #1;
    n_checks++;
    if (TIMER_INT !== 1'b0) begin n_errors++; $display("FAIL periodic_tick8: got %b, required 0", TIMER_INT); end
    // This W1C commits on tick 12, an expiry: the set must win.
    xfer(1'b1, 8'h0C, 32'h1, 32'h0, 1'b0);
    n_checks++;
    if (TIMER_INT !== 1'b1) begin n_errors++; $display("FAIL periodic_set_beats_clear: got %b, required 1", TIMER_INT); end
    // Disable commits on tick 16: VALUE reloaded to 2 at 15, decremented to 1 at 16, then frozen.
    xfer(1'b1, 8'h00, 32'h0, 32'h0, 1'b0);
    xfer(1'b0, 8'h08, 32'h0, 32'h1, 1'b0);
    xfer(1'b0, 8'h0C, 32'h0, 32'h1, 1'b0);
    xfer(1'b1, 8'h0C, 32'h1, 32'h0, 1'b0);
    xfer(1'b0, 8'h0C, 32'h0, 32'h0, 1'b0);
    xfer(1'b0, 8'h08, 32'h0, 32'h1, 1'b0);
  endtask

  task automatic test_errors;
    xfer(1'b0, 8'h1C, 32'h0, 32'h0, 1'b1);
    xfer(1'b1, 8'h08, 32'h55, 32'h0, 1'b1);
    xfer(1'b0, 8'h08, 32'h0, 32'h1, 1'b0);
    xfer(1'b0, 8'h80, 32'h0, 32'h0, 1'b1);
    xfer(1'b1, 8'h30, 32'h1234, 32'h0, 1'b1);
    xfer(1'b0, 8'h10, 32'h0, 32'hA5A5_0001, 1'b0);
`ifndef APB_TIMER_PRESCALE_EN
    xfer(1'b0, 8'h14, 32'h0, 32'h0, 1'b1);
    xfer(1'b1, 8'h14, 32'h4, 32'h0, 1'b1);
`endif
  endtask

  task automatic test_reset_mid;
    @(posedge FAB_CLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h10; PWDATA = 32'hDEAD_BEEF;
    @(posedge FAB_CLK); #1;
    PENABLE = 1'b1;
    #2;
    FAB_RESET = 1'b1;
    #1;
    n_checks++;
    if (PREADY !== 1'b0) begin n_errors++; $display("FAIL reset_mid_pready: got %b, required 0", PREADY); end
    @(posedge FAB_CLK); #1;
    n_checks++;
    if (PREADY !== 1'b0) begin n_errors++; $display("FAIL reset_mid_pready_hold: got %b, required 0", PREADY); end
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    FAB_RESET = 1'b0;
    xfer(1'b0, 8'h10, 32'h0, 32'h0, 1'b0);
    xfer(1'b0, 8'h00, 32'h0, 32'h0, 1'b0);
  endtask

`ifdef APB_TIMER_PRESCALE_EN
  task automatic test_prescale;
    logic exp_int;
    xfer(1'b1, 8'h14, 32'd4, 32'h0, 1'b0);
    xfer(1'b0, 8'h14, 32'h0, 32'd4, 1'b0);
    xfer(1'b1, 8'h04, 32'd1, 32'h0, 1'b0);
    xfer(1'b1, 8'h00, 32'h5, 32'h0, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      @(posedge FAB_CLK); #1;
      exp_int = (k == 10);
      n_checks++;
      if (TIMER_INT !== exp_int) begin
        n_errors++;
        $display("FAIL prescale_int cycle %0d: got %b, required %b", k, TIMER_INT, exp_int);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_scratch_load();
    test_oneshot();
    test_periodic();
    test_errors();
    test_reset_mid();
`ifdef APB_TIMER_PRESCALE_EN
    test_prescale();
`endif
    repeat (3) @(posedge FAB_CLK);
    #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: %0d responses outstanding, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
